traffic_light: RTL and testbench

// - Single-intersection traffic-light sequencer: cycles RED -> GREEN -> YELLOW -> RED.
// - Each phase lasts a programmable number of clock cycles.
// - Drives a 2-bit encoded light code to downstream lamp drivers or decoders.
// - Free-running; no external request or sensor inputs.
//

---
 rtl/traffic_light.sv | 96 +++++++++
 tb/tb_traffic_light.sv | 116 +++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// Single-intersection traffic-light sequencer: RED -> GREEN -> YELLOW -> RED,
// each phase held for a programmable number of clock cycles.
module traffic_light #(
   parameter int RED_CYCLES    = 4,
   parameter int GREEN_CYCLES  = 4,
   parameter int YELLOW_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rstb,
   output logic [1:0] light
);

   localparam int MAX_RG  = (RED_CYCLES > GREEN_CYCLES) ? RED_CYCLES : GREEN_CYCLES;
   localparam int MAX_CYC = (MAX_RG > YELLOW_CYCLES) ? MAX_RG : YELLOW_CYCLES;
   localparam int unsigned CNT_W = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;

   // Phase lengths below one cycle cannot be sequenced
   if (RED_CYCLES < 1 || GREEN_CYCLES < 1 || YELLOW_CYCLES < 1) begin : g_bad_cfg
      $error("traffic_light: every phase length must be at least 1 cycle");
   end

   typedef enum logic [1:0] {
      ST_RED    = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       light_q, light_d;

   // State, phase counter and output register; reset forces RED with a cleared counter
   always_ff @(posedge clk) begin
      if (rstb) begin
         state_q <= ST_RED;
         cnt_q   <= '0;
         light_q <= LIGHT_RED;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         light_q <= light_d;
      end
   end

   // Next state: advance and clear the counter on the last cycle of each phase
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
         ST_RED: begin
            if (cnt_q == RED_LAST) begin
               state_d = ST_GREEN;
               cnt_d   = '0;
            end
         end
         ST_GREEN: begin
            if (cnt_q == GREEN_LAST) begin
               state_d = ST_YELLOW;
               cnt_d   = '0;
            end
         end
         ST_YELLOW: begin
            if (cnt_q == YELLOW_LAST) begin
               state_d = ST_RED;
               cnt_d   = '0;
            end
         end
         default: begin
            // Illegal encoding recovers to a fresh RED phase
            state_d = ST_RED;
            cnt_d   = '0;
         end
      endcase
   end

   // Light code for the upcoming state, registered so it tracks state_q exactly
   always_comb begin
      light_d = LIGHT_RED;
      case (state_d)
         ST_GREEN:  light_d = LIGHT_GREEN;
         ST_YELLOW: light_d = LIGHT_YELLOW;
         default:   light_d = LIGHT_RED;
      endcase
   end

   assign light = light_q;

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: default-timing and all-ones-timing instances share
// one reset; expected light codes are queued per cycle and checked after each edge.
module tb_traffic_light;

   logic       clk;
   logic       rstb;
   logic [1:0] light_a;
   logic [1:0] light_b;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_qa[$];
   logic [1:0] exp_qb[$];
   string      tag_q[$];

   int pos_a = 0;   // position within the 10-cycle default period
   int pos_b = 0;   // position within the 3-cycle minimal period

   traffic_light dut_a (
      .clk   (clk),
      .rstb  (rstb),
      .light (light_a)
   );

   traffic_light #(
      .RED_CYCLES    (1),
      .GREEN_CYCLES  (1),
      .YELLOW_CYCLES (1)
   ) dut_b (
      .clk   (clk),
      .rstb  (rstb),
      .light (light_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match
   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected light from a position in the period, given phase lengths
   function automatic logic [1:0] code_at(input int pos, input int r, input int g);
      if (pos < r)          return 2'b00;
      else if (pos < r + g) return 2'b01;
      else                  return 2'b10;
   endfunction

   // Drive one cycle of reset/run and queue what both lights must show after the edge
   task automatic step(input logic rst, input string tag);
      @(negedge clk);
      rstb = rst;
      if (rst) begin
         pos_a = 0;
         pos_b = 0;
      end else begin
         pos_a = (pos_a + 1) % 10;
         pos_b = (pos_b + 1) % 3;
      end
      exp_qa.push_back(code_at(pos_a, 4, 4));
      exp_qb.push_back(code_at(pos_b, 1, 1));
      tag_q.push_back(tag);
   endtask

   // Monitor: compare one queued expectation shortly after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_qa.size() > 0) begin
            string t;
            t = tag_q.pop_front();
            chk({t, "_a"}, light_a, exp_qa.pop_front());
            chk({t, "_b"}, light_b, exp_qb.pop_front());
         end
      end
   end

   initial begin
      rstb = 1'b1;

      // Reset held: RED every cycle
      for (int i = 0; i < 21; i++) step(1'b1, "rst_hold");

      // One full default period plus the return to RED
      for (int i = 0; i < 11; i++) step(1'b0, "seq");

      // Re-sync, then reset during GREEN cycle 2
      step(1'b1, "resync");
      for (int i = 0; i < 5; i++) step(1'b0, "to_green2");
      step(1'b1, "mid_rst");
      for (int i = 0; i < 12; i++) step(1'b0, "after_rst");

      // Three more full periods of wrap-around
      for (int i = 0; i < 30; i++) step(1'b0, "wrap");

      // Drain the scoreboard within a bounded number of edges
      for (int i = 0; i < 5 && exp_qa.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_qa.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d pending exp=0", exp_qa.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
